float_to_fixed: RTL and testbench
=================================

FLOAT_TO_FIXED -- requirements
Module: float_to_fixed

Interface
REQ-001 SHALL have parameter: FRAC_BITS, 16, number of fractional bits in the output fixed-point word (legal 0..30).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_data  input  32  IEEE-754 single operand; in_valid  input  1; in_ready  output  1.
REQ-005 SHALL have ports: out_data  output  32  signed two's-complement value equal to in_data*2^FRAC_BITS; out_valid  output  1; out_ready  input  1.
REQ-006 SHALL have ports: out_ovf  output  1  saturated; out_inv  output  1  NaN input; out_inexact  output  1  nonzero bits discarded.

Function
REQ-007 SHALL accept an operand only on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in IDLE.
REQ-008 SHALL implement FSM states IDLE, DECODE, SHIFT, ROUND, DONE; IDLE->DECODE on accept.
REQ-009 In DECODE it SHALL split sign s, exponent E, and mantissa m={1,frac}, and compute k=(E-127)+FRAC_BITS-23.
REQ-010 E=255 with frac!=0 (NaN): DECODE->DONE, out_data=0, out_inv=1.
REQ-011 E=255 with frac=0 (Inf), or E!=255 with (E-127)+FRAC_BITS>=31: DECODE->DONE, out_data=0x7FFFFFFF (s=0) or 0x80000000 (s=1), out_ovf=1.
REQ-012 E=0 (zero or denormal, flushed): DECODE->DONE, out_data=0, out_inexact=1 if frac!=0.
REQ-013 Otherwise DECODE->SHIFT with step count n=k if k>=0, else n=min(-k,26); n=0 SHALL pass directly to ROUND.
REQ-014 SHIFT SHALL move the magnitude one bit per cycle (left if k>0, right if k<0), tracking guard and sticky bits on right shifts; SHIFT->ROUND when the count reaches 0.
REQ-015 ROUND SHALL apply the rounding rule of REQ-024, set out_inexact if guard|sticky, negate if s=1, and saturate with out_ovf=1 if the rounded magnitude exceeds 2^31-1.
REQ-016 DONE SHALL hold out_valid=1 and all outputs stable until out_ready=1; DONE->IDLE on that edge.
REQ-017 Latency SHALL be exactly n+3 cycles from accept edge to out_valid for the shift path and 2 cycles for the DECODE->DONE bypass; throughput one operand per transaction (no overlap).
REQ-018 out_ovf, out_inv, out_inexact SHALL be valid only while out_valid=1 and SHALL be cleared when a new operand is accepted.
REQ-019 -0.0 SHALL produce out_data=0 with no flags.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, out_data=0, all flags 0.
REQ-021 Reset asserted in any state, including mid-SHIFT or DONE with out_ready=0, SHALL abort the transaction with no output handshake.
REQ-022 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro F2F_ROUND_NEAREST_EN selects the rounding rule.
REQ-024 Defined: round-to-nearest-even on magnitude (guard=1 and (sticky=1 or LSB=1) increments). Undefined: truncate toward zero, guard/sticky used only for out_inexact.

Verification
REQ-025 in_data=0x3F800000 (1.0), out_ready=1 -> out_data=0x00010000, no flags, out_valid 10 cycles after accept (n=7).
REQ-026 in_data=0xC0200000 (-2.5) -> out_data=0xFFFD8000, no flags.
REQ-027 in_data=0x7F800000 -> 0x7FFFFFFF out_ovf=1; 0xFF800000 -> 0x80000000 out_ovf=1; 0x7FC00000 -> 0x00000000 out_inv=1; each at 2-cycle latency.
REQ-028 in_data=0x37C00000 (1.5 LSB) -> out_data=0x00000002 with macro, 0x00000001 without; out_inexact=1 both.
REQ-029 Hold out_ready=0 for 5 cycles in DONE -> out_data/flags stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next cycle, second operand then accepted.
REQ-030 Pulse rst_n=0 during SHIFT of 1.0 -> out_valid stays 0, outputs 0, next operand 0x40000000 yields 0x00020000.

Source files
------------

// File: rtl/float_to_fixed.sv
// IEEE-754 single -> signed Q(31-FRAC_BITS).FRAC_BITS converter with a serial one-bit-per-cycle shifter.
// Latency n+3 edges for the shift path, 2 for special/zero/saturating operands; one operand at a time.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready. F2F_ROUND_NEAREST_EN selects RNE, otherwise truncation.
module float_to_fixed #(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_ovf,
    output logic        out_inv,
    output logic        out_inexact
);

    typedef enum logic [2:0] {IDLE, DECODE, SHIFT, ROUND, DONE} state_t;

    localparam logic signed [10:0] FB = 11'(FRAC_BITS);

    state_t      state_q, state_d;
    logic [31:0] op_q, op_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_ovf_q, out_ovf_d;
    logic        out_inv_q, out_inv_d;
    logic        out_inexact_q, out_inexact_d;

    logic [7:0]         exp_w;
    logic [22:0]        frac_w;
    logic signed [10:0] scale;
    logic signed [10:0] k;
    logic [4:0]         shift_n;
    logic               round_up;
    logic [32:0]        mag_rnd;

    // scale is the weight of the hidden bit in the output word; k is how far the 24-bit mantissa must move.
    assign exp_w   = op_q[30:23];
    assign frac_w  = op_q[22:0];
    assign scale   = $signed({3'b000, exp_w}) - 11'sd127 + FB;
    assign k       = scale - 11'sd23;
    assign shift_n = (k > 11'sd0)   ? 5'(k) :
                     (k < -11'sd26) ? 5'd26 : 5'(-k);

`ifdef F2F_ROUND_NEAREST_EN
    assign round_up = guard_q & (sticky_q | mag_q[0]);
`else
    assign round_up = 1'b0;
`endif
    assign mag_rnd = {1'b0, mag_q} + 33'(round_up);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        sign_d        = sign_q;
        mag_d         = mag_q;
        guard_d       = guard_q;
        sticky_d      = sticky_q;
        cnt_d         = cnt_q;
        left_d        = left_q;
        in_ready_d    = in_ready_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_ovf_d     = out_ovf_q;
        out_inv_d     = out_inv_q;
        out_inexact_d = out_inexact_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d          = in_data;
                    state_d       = DECODE;
                    in_ready_d    = 1'b0;
                    out_ovf_d     = 1'b0;
                    out_inv_d     = 1'b0;
                    out_inexact_d = 1'b0;
                end
            end
            DECODE: begin
                sign_d   = op_q[31];
                mag_d    = {8'd0, 1'b1, frac_w};
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                left_d   = (k > 11'sd0);
                cnt_d    = shift_n;
                if (exp_w == 8'hFF && frac_w != 23'd0) begin
                    out_data_d  = 32'd0;
                    out_inv_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (exp_w == 8'hFF || scale >= 11'sd31) begin
                    out_data_d  = op_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    out_ovf_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (exp_w == 8'd0) begin
                    out_data_d    = 32'd0;
                    out_inexact_d = (frac_w != 23'd0);
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end else if (shift_n == 5'd0) begin
                    state_d = ROUND;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = {mag_q[30:0], 1'b0};
                end else begin
                    mag_d    = {1'b0, mag_q[31:1]};
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                out_inexact_d = guard_q | sticky_q;
                if (mag_rnd > 33'h0_7FFF_FFFF) begin
                    out_data_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    out_ovf_d  = 1'b1;
                end else begin
                    out_data_d = sign_q ? (~mag_rnd[31:0] + 32'd1) : mag_rnd[31:0];
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= 32'd0;
            sign_q        <= 1'b0;
            mag_q         <= 32'd0;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            cnt_q         <= 5'd0;
            left_q        <= 1'b0;
            in_ready_q    <= 1'b1;
            out_data_q    <= 32'd0;
            out_valid_q   <= 1'b0;
            out_ovf_q     <= 1'b0;
            out_inv_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            sign_q        <= sign_d;
            mag_q         <= mag_d;
            guard_q       <= guard_d;
            sticky_q      <= sticky_d;
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            in_ready_q    <= in_ready_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_ovf_q     <= out_ovf_d;
            out_inv_q     <= out_inv_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_ovf     = out_ovf_q;
    assign out_inv     = out_inv_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed and random checks of float_to_fixed against an arithmetic reference model.
module tb_float_to_fixed;
    localparam int FRAC_BITS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_ovf;
    logic        out_inv;
    logic        out_inexact;

    int n_pass = 0;
    int n_total = 0;

    float_to_fixed #(.FRAC_BITS(FRAC_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ovf    (out_ovf),
        .out_inv    (out_inv),
        .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Value = 1.frac * 2^(e-127) * 2^FRAC_BITS, computed as an integer quotient and remainder.
    function automatic void model(input logic [31:0] d, output logic [31:0] r, output logic [2:0] fl,
                                  output int lat);
        int e, fr, sh, rs;
        longint m, q, rem, half, mag;
        logic ovf, inv, inex;
        e = int'(d[30:23]);
        fr = int'(d[22:0]);
        r = 32'd0; ovf = 1'b0; inv = 1'b0; inex = 1'b0; lat = 2; mag = 0;
        if (e == 255 && fr != 0) begin
            inv = 1'b1;
        end else if (e == 255 || e - 127 + FRAC_BITS >= 31) begin
            ovf = 1'b1;
            r = d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (e == 0) begin
            inex = (fr != 0);
        end else begin
            m = longint'(fr) + (longint'(1) << 23);
            sh = e - 150 + FRAC_BITS;
            if (sh >= 0) begin
                mag = m << sh;
                lat = sh + 3;
            end else begin
                rs = (-sh > 40) ? 40 : -sh;
                lat = ((-sh > 26) ? 26 : -sh) + 3;
                q = m >> rs;
                rem = m - (q << rs);
                half = longint'(1) << (rs - 1);
                inex = (rem != 0);
`ifdef F2F_ROUND_NEAREST_EN
                if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
                mag = q;
            end
            if (mag > longint'(32'h7FFF_FFFF)) begin
                ovf = 1'b1;
                r = d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                r = d[31] ? 32'(-mag) : 32'(mag);
            end
        end
        fl = {ovf, inv, inex};
    endfunction

    // Drive one operand, measure accept wait and latency, hold out_ready low for 'hold' cycles, then release.
    task automatic do_op(input string name, input logic [31:0] d, input logic [31:0] er, input logic [2:0] ef,
                         input int el, input int hold, input bit junk_en, input logic [31:0] junk,
                         output int wt);
        int lat;
        @(negedge clk);
        in_data = d; in_valid = 1'b1; out_ready = 1'b0;
        wt = 0;
        while (!in_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        if (!in_ready) begin
            check({name, " accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 200);
        check({name, " latency"}, 32'(lat), 32'(el));
        check({name, " data"}, out_data, er);
        check({name, " flags"}, {29'd0, out_ovf, out_inv, out_inexact}, {29'd0, ef});
        for (int i = 0; i < hold; i++) begin
            if (junk_en) begin
                in_data = junk;
                in_valid = 1'b1;
            end
            @(negedge clk);
            check($sformatf("%s hold%0d valid", name, i), {31'd0, out_valid}, 32'd1);
            check($sformatf("%s hold%0d data", name, i), out_data, er);
            check($sformatf("%s hold%0d flags", name, i), {29'd0, out_ovf, out_inv, out_inexact}, {29'd0, ef});
            check($sformatf("%s hold%0d in_ready", name, i), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({name, " released valid"}, {31'd0, out_valid}, 32'd0);
        check({name, " released in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd, mr;
        logic [2:0]  mf;
        logic [31:0] r028;
        int ml, wt, seen;

        repeat (3) @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset flags", {29'd0, out_ovf, out_inv, out_inexact}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        do_op("one", 32'h3F80_0000, 32'h0001_0000, 3'b000, 10, 0, 1'b0, 32'd0, wt);
        check("first accept wait", 32'(wt), 32'd0);
        do_op("minus2p5", 32'hC020_0000, 32'hFFFD_8000, 3'b000, 9, 0, 1'b0, 32'd0, wt);
        do_op("pos_inf", 32'h7F80_0000, 32'h7FFF_FFFF, 3'b100, 2, 0, 1'b0, 32'd0, wt);
        do_op("neg_inf", 32'hFF80_0000, 32'h8000_0000, 3'b100, 2, 0, 1'b0, 32'd0, wt);
        do_op("nan", 32'h7FC0_0000, 32'h0000_0000, 3'b010, 2, 0, 1'b0, 32'd0, wt);
`ifdef F2F_ROUND_NEAREST_EN
        r028 = 32'd2;
`else
        r028 = 32'd1;
`endif
        do_op("lsb1p5", 32'h37C0_0000, r028, 3'b001, 26, 0, 1'b0, 32'd0, wt);
        do_op("neg_zero", 32'h8000_0000, 32'h0000_0000, 3'b000, 2, 0, 1'b0, 32'd0, wt);
        do_op("denorm", 32'h0000_0001, 32'h0000_0000, 3'b001, 2, 0, 1'b0, 32'd0, wt);
        do_op("max_fit", 32'h46FF_FFFF, 32'h7FFF_FF80, 3'b000, 10, 0, 1'b0, 32'd0, wt);
        do_op("first_sat", 32'h4700_0000, 32'h7FFF_FFFF, 3'b100, 2, 0, 1'b0, 32'd0, wt);
        do_op("neg_sat", 32'hC700_0000, 32'h8000_0000, 3'b100, 2, 0, 1'b0, 32'd0, wt);
        do_op("min_norm", 32'h0080_0000, 32'h0000_0000, 3'b001, 29, 0, 1'b0, 32'd0, wt);

        do_op("held1p5", 32'h3FC0_0000, 32'h0001_8000, 3'b000, 10, 5, 1'b1, 32'h4040_0000, wt);
        do_op("after_hold", 32'h4040_0000, 32'h0003_0000, 3'b000, 9, 0, 1'b0, 32'd0, wt);
        check("after_hold accept wait", 32'(wt), 32'd0);

        @(negedge clk);
        in_data = 32'h3F80_0000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midshift rst out_valid", {31'd0, out_valid}, 32'd0);
        check("midshift rst out_data", out_data, 32'd0);
        check("midshift rst flags", {29'd0, out_ovf, out_inv, out_inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midshift abort no valid", 32'(seen), 32'd0);
        do_op("two", 32'h4000_0000, 32'h0002_0000, 3'b000, 9, 0, 1'b0, 32'd0, wt);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) rd = $urandom;
            else rd = {1'($urandom_range(0, 1)), 8'($urandom_range(95, 160)), 23'($urandom)};
            model(rd, mr, mf, ml);
            do_op($sformatf("rnd%0d_%h", i, rd), rd, mr, mf, ml, $urandom_range(0, 2), 1'b0, 32'd0, wt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
